spawn_pos_gen: RTL



---
 rtl/game_pkg.sv | 36 +++
 rtl/spawn_pos_gen_lfsr.sv | 19 +
 rtl/spawn_pos_gen.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants: platform geometry table, player-avoid distance and
// the spawn FSM state encoding.
package game_pkg;

  // One platform: left edge, walkable length and collision (top surface) y.
  typedef struct packed {
    logic [10:0] x_start;
    logic [9:0]  length;
    logic [10:0] y_coll;
  } plat_t;

  // Entries 0..5 are the original P1..P6 platforms; 6..7 are spare slots
  // with safe geometry so larger builds still produce on-screen positions.
  localparam plat_t PLAT_TABLE [8] = '{
    '{x_start: 11'd100, length: 10'd50,  y_coll: 11'd400},
    '{x_start: 11'd300, length: 10'd120, y_coll: 11'd350},
    '{x_start: 11'd500, length: 10'd80,  y_coll: 11'd300},
    '{x_start: 11'd50,  length: 10'd150, y_coll: 11'd250},
    '{x_start: 11'd700, length: 10'd100, y_coll: 11'd200},
    '{x_start: 11'd400, length: 10'd200, y_coll: 11'd150},
    '{x_start: 11'd200, length: 10'd64,  y_coll: 11'd100},
    '{x_start: 11'd600, length: 10'd64,  y_coll: 11'd100}
  };

  // Minimum horizontal clearance between a new spawn and the player.
  localparam int AVOID_DX = 40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK  = 3'd1,
    ST_MOD   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } spawn_state_t;

endpackage

// File: rtl/spawn_pos_gen_lfsr.sv
// lfsr_gen: free-running right-shift Galois LFSR. The default tap mask
// implements x^16+x^14+x^13+x^11+1; SEED must be non-zero.
module lfsr_gen #(
  parameter int             W    = 16,
  parameter logic [W-1:0]   SEED = 16'hACE1,
  parameter logic [W-1:0]   TAPS = 16'hB400
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] lfsr
);

  // Advance every cycle; the feedback bit is the one shifted out.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
  end

endmodule

// File: rtl/spawn_pos_gen.sv
// spawn_pos_gen: picks a pseudo-random platform and an x offset on it and
// reports the spawn coordinate. Optional build macro SPAWN_AVOID_EN rejects
// spawns landing too close to the player (avoid_x/avoid_y).
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for req, busy low
// ST_PICK    | draw platform index from LFSR, re-pick on reject
// ST_MOD     | reduce random offset modulo platform length by subtraction
// ST_CHECK   | form x/y, optional player-proximity discard
// ST_DONE    | one-cycle done pulse, outputs already registered
module spawn_pos_gen
  import game_pkg::*;
#(
  parameter int                PLATFORM_NUM = 6,
  parameter int                POS_W        = 11,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] SEED         = 16'hACE1,
  parameter int                OBJ_HEIGHT   = 20,
  parameter int                RETRY_MAX    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             busy,
  output logic             done,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [2:0]       plat_idx,
  input  logic [POS_W-1:0] avoid_x,
  input  logic [POS_W-1:0] avoid_y
);

  localparam int               RW       = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [3:0]       PNUM     = 4'(PLATFORM_NUM);
  localparam logic [2:0]       LAST_RST = 3'(PLATFORM_NUM - 1);
  localparam logic [POS_W-1:0] OBJ_H    = POS_W'(OBJ_HEIGHT);

  spawn_state_t      state;
  logic [LFSR_W-1:0] lfsr;
  logic [2:0]        cand, last_idx, pick_raw, pick_fwd, pick_sel;
  logic [RW-1:0]     retry_cnt;
  logic [9:0]        r;
  logic              pick_reject, pick_force, accept;
  logic [POS_W-1:0]  calc_x, calc_y;
  plat_t             plat;
  logic              unused_lfsr;

  lfsr_gen #(.W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Only a few LFSR bits feed the picker; the rest just carry state.
  assign unused_lfsr = ^lfsr;

  assign pick_raw    = lfsr[2:0];
  assign pick_force  = (retry_cnt == RW'(RETRY_MAX));
  assign pick_fwd    = (last_idx == LAST_RST) ? 3'd0 : last_idx + 3'd1;
  // With a single platform the no-repeat rule would lock the picker out.
  assign pick_reject = ({1'b0, pick_raw} >= PNUM) ||
                       ((PLATFORM_NUM > 1) && (pick_raw == last_idx));
  assign pick_sel    = pick_force ? pick_fwd : pick_raw;

  assign plat   = PLAT_TABLE[cand];
  assign calc_x = POS_W'(plat.x_start) + POS_W'(r);
  assign calc_y = POS_W'(plat.y_coll) - OBJ_H;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

`ifdef SPAWN_AVOID_EN
  logic [3:0]       disc_cnt;
  logic [POS_W-1:0] dist;
  logic             near;

  assign dist   = (calc_x >= avoid_x) ? calc_x - avoid_x : avoid_x - calc_x;
  assign near   = (calc_y == avoid_y) && (dist < POS_W'(AVOID_DX));
  // After eight consecutive discards take the candidate to bound latency.
  assign accept = !near || (disc_cnt == 4'd8);

  // Count consecutive proximity discards; any accepted spawn clears it.
  always_ff @(posedge clk) begin
    if (rst)                    disc_cnt <= '0;
    else if (state == ST_CHECK) disc_cnt <= accept ? 4'd0 : disc_cnt + 4'd1;
  end
`else
  logic unused_avoid;

  assign accept       = 1'b1;
  assign unused_avoid = ^{avoid_x, avoid_y};
`endif

  // Main sequencer; reset lands in PICK so a spawn is produced without req.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PICK;
      last_idx  <= LAST_RST;
      retry_cnt <= '0;
      cand      <= '0;
      r         <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      plat_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req) state <= ST_PICK;
        ST_PICK: begin
          if (pick_force || !pick_reject) begin
            cand  <= pick_sel;
            r     <= lfsr[LFSR_W-1 -: 10];
            state <= ST_MOD;
          end else begin
            retry_cnt <= retry_cnt + RW'(1);
          end
        end
        ST_MOD: begin
          if (r >= plat.length) r <= r - plat.length;
          else                  state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (accept) begin
            pos_x     <= calc_x;
            pos_y     <= calc_y;
            plat_idx  <= cand;
            last_idx  <= cand;
            retry_cnt <= '0;
            state     <= ST_DONE;
          end else begin
            state <= ST_PICK;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
